// File: rtl/mmu_pkg.sv
// Shared constants and FSM encoding for the MMU packet feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmu_pkg;

    localparam int DEF_DATA_BIT    = 8;
    localparam int DEF_ADDR_BIT    = 4;
    localparam int DEF_FRAME_BIT   = 2;
    localparam int BYTES_PER_FRAME = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT_RDY,
        ST_WR_BURST,
        ST_RD_BURST,
        ST_GAP
    } feeder_state_t;

endpackage

// File: rtl/mmu_byte_fifo.sv
// Byte FIFO, first-word-fall-through, with occupancy count and synchronous clear.
// Latency: a pushed byte is visible on head_dat the cycle after the push.
// Backpressure: pushes when full and pops when empty are ignored; the caller sizes traffic.
module mmu_byte_fifo #(
    parameter int DATA_BIT = 8,
    parameter int DEPTH    = 32,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_BIT-1:0] push_dat,
    input  logic                pop,
    output logic [DATA_BIT-1:0] head_dat,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_BIT-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed since the count gates what is readable.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mmu_pkt_feeder.sv
// Store-and-forward feeder: buffers a write packet, then drives the MMU as one contiguous burst.
// Latency: write = L fill + 1 wait + L burst + GAP_CYC; read = 1 + L + RD_LAT + GAP_CYC cycles.
// Backpressure: cmd_ready only in IDLE, in_ready only in FILL; read return stream has none.
module mmu_pkt_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_BIT   = DEF_DATA_BIT,
    parameter int ADDR_BIT   = DEF_ADDR_BIT,
    parameter int FRAME_BIT  = DEF_FRAME_BIT,
    parameter int FIFO_DEPTH = 32,
    parameter int RD_LAT     = 2,
    parameter int GAP_CYC    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [ADDR_BIT-1:0]  cmd_addr,
    input  logic [FRAME_BIT-1:0] cmd_frame,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BIT-1:0]  in_data,
    input  logic                 mmu_ready,
    input  logic [DATA_BIT-1:0]  mmu_rd_data,
    output logic                 mmu_start,
    output logic                 mmu_rw_ena,
    output logic [ADDR_BIT-1:0]  mmu_addr,
    output logic [FRAME_BIT-1:0] mmu_frame,
    output logic [DATA_BIT-1:0]  mmu_wr_data,
    output logic                 out_valid,
    output logic [DATA_BIT-1:0]  out_data,
    output logic                 busy
);

    localparam int CNT_W  = 16;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    feeder_state_t       state;
    feeder_state_t       state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    len;
    logic [CNT_W-1:0]    cmd_len;
    logic                cur_rw;
    logic                cmd_fire;
    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_BIT-1:0] fifo_dat;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic                rd_capture;

    assign cmd_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_FILL);
    assign busy      = (state != ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign fifo_push = in_valid && in_ready;
    // Pop one cycle ahead so the registered wr_data lines up with each burst cycle.
    assign fifo_pop  = (state_next == ST_WR_BURST);
    // Read bytes arrive RD_LAT cycles into the burst and last for L cycles.
    assign rd_capture = (state == ST_RD_BURST) && (cnt >= CNT_W'(RD_LAT));

    // Frame count 0 is treated as a single frame.
    always_comb begin
        cmd_len = CNT_W'(cmd_frame) * CNT_W'(BYTES_PER_FRAME);
        if (cmd_frame == '0) cmd_len = CNT_W'(BYTES_PER_FRAME);
    end

    mmu_byte_fifo #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (FIFO_DEPTH),
        .CNT_W    (FCNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (in_data),
        .pop      (fifo_pop),
        .head_dat (fifo_dat),
        .count    (fifo_cnt)
    );

    // Next-state decode; mmu_ready only matters while waiting to start.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_next = cmd_rw ? ST_WAIT_RDY : ST_FILL;
            end
            ST_FILL: begin
                if (fifo_push && (CNT_W'(fifo_cnt) == len - CNT_W'(1)))
                    state_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (mmu_ready) state_next = cur_rw ? ST_RD_BURST : ST_WR_BURST;
            end
            ST_WR_BURST: begin
                if (cnt == len - CNT_W'(1)) state_next = ST_GAP;
            end
            ST_RD_BURST: begin
                if (cnt == len + CNT_W'(RD_LAT) - CNT_W'(1)) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus a per-state cycle counter that restarts on every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Command latch; addr/frame stay put for the whole burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_rw    <= 1'b0;
            len       <= '0;
            mmu_addr  <= '0;
            mmu_frame <= '0;
        end else if (cmd_fire) begin
            cur_rw    <= cmd_rw;
            len       <= cmd_len;
            mmu_addr  <= cmd_addr;
            mmu_frame <= cmd_frame;
        end
    end

    // Registered MMU drive and read-return stream, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmu_start   <= 1'b0;
            mmu_rw_ena  <= 1'b0;
            mmu_wr_data <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            mmu_start  <= (state_next == ST_WR_BURST) || (state_next == ST_RD_BURST);
            mmu_rw_ena <= (state_next == ST_RD_BURST);
            if (fifo_pop) mmu_wr_data <= fifo_dat;
            out_valid  <= rd_capture;
            if (rd_capture) out_data <= mmu_rd_data;
        end
    end

endmodule

// File: tb/tb_mmu_pkt_feeder.sv
// Directed bench for the MMU packet feeder: writes, reads, stalls, frame sizes, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmu_pkt_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [3:0] cmd_addr;
    logic [1:0] cmd_frame;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       mmu_ready;
    logic [7:0] mmu_rd_data;
    logic       mmu_start;
    logic       mmu_rw_ena;
    logic [3:0] mmu_addr;
    logic [1:0] mmu_frame;
    logic [7:0] mmu_wr_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] wr_q [$];
    logic [7:0] cap [0:31];
    int         cap_n;
    int         cap_gap;
    int         cap_busy;
    bit         cap_addr_ok;
    bit         cap_rw_ok;
    bit         cap_split;
    bit         cap_timeout;
    logic [1:0] cap_frame;

    always #5 clk = ~clk;

    mmu_pkt_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_frame   (cmd_frame),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mmu_ready   (mmu_ready),
        .mmu_rd_data (mmu_rd_data),
        .mmu_start   (mmu_start),
        .mmu_rw_ena  (mmu_rw_ena),
        .mmu_addr    (mmu_addr),
        .mmu_frame   (mmu_frame),
        .mmu_wr_data (mmu_wr_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it for one accepting edge.
    task automatic send_cmd(input logic rw, input logic [3:0] addr, input logic [1:0] frame,
                            input bit hold_first_byte);
        int waited = 0;
        while (!cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_wait: cmd_ready=%0b required 1 within 100 cycles", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_frame = frame;
        if (hold_first_byte) begin
            in_valid = 1'b1;
            in_data  = wr_q[0];
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Stream wr_q into the fill phase, optionally with an idle cycle before every byte.
    task automatic fill(input bit toggle);
        for (int i = 0; i < wr_q.size(); i++) begin
            if (toggle) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = wr_q[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Observe a write burst through to cmd_ready, recording bytes and timing.
    task automatic capture_wr(input logic [3:0] exp_addr);
        int  cyc   = 0;
        bit  seen  = 0;
        bit  ended = 0;
        cap_n = 0; cap_gap = 0; cap_busy = 0;
        cap_addr_ok = 1; cap_rw_ok = 1; cap_split = 0; cap_timeout = 0;
        cap_frame = '0;
        while (!(ended && cmd_ready)) begin
            if (cyc >= 300) begin
                cap_timeout = 1;
                break;
            end
            if (busy) cap_busy++;
            if (mmu_start) begin
                if (ended) cap_split = 1;
                else begin
                    if (!seen) cap_frame = mmu_frame;
                    seen = 1;
                    if (cap_n < 32) cap[cap_n] = mmu_wr_data;
                    cap_n++;
                    if (mmu_addr != exp_addr) cap_addr_ok = 0;
                    if (mmu_rw_ena) cap_rw_ok = 0;
                end
            end else if (seen) begin
                ended = 1;
                if (!cmd_ready) cap_gap++;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (mmu_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %0b want 0", mmu_start); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests++; if (mmu_wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", mmu_wr_data); end
        tests++; if (mmu_addr !== 4'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mmu_addr); end
        tests++; if (mmu_rw_ena !== 1'b0) begin fails++; $display("FAIL reset_rw_ena: got %0b want 0", mmu_rw_ena); end
        rst = 1'b0;
        tick();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_single_write();
        wr_q = '{8'h08, 8'h33, 8'hac, 8'h34, 8'h99, 8'h41, 8'h0c, 8'h14};
        mmu_ready = 1'b1;
        // byte 0 offered alongside the command must not be taken twice
        send_cmd(1'b0, 4'h1, 2'd1, 1'b1);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL wr1_in_ready_fill: got %0b want 1", in_ready); end
        fill(1'b0);
        capture_wr(4'h1);
        tests++; if (cap_timeout) begin fails++; $display("FAIL wr1_timeout: burst not finished within budget"); end
        tests++; if (cap_n != 8) begin fails++; $display("FAIL wr1_len: got %0d start cycles want 8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (cap[i] !== wr_q[i]) begin fails++; $display("FAIL wr1_byte%0d: got %h want %h", i, cap[i], wr_q[i]); end
        end
        tests++; if (!cap_rw_ok) begin fails++; $display("FAIL wr1_rw_ena: got 1 during burst want 0"); end
        tests++; if (!cap_addr_ok) begin fails++; $display("FAIL wr1_addr: got other than 1 want 1"); end
        tests++; if (cap_gap != 2) begin fails++; $display("FAIL wr1_gap: got %0d want 2", cap_gap); end
        tests++; if (cap_busy != 11) begin fails++; $display("FAIL wr1_busy_after_fill: got %0d want 11", cap_busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] addrs [0:2];
        addrs[0] = 4'h5; addrs[1] = 4'h3; addrs[2] = 4'h2;
        mmu_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wr_q = '{8'h99, 8'h30, 8'h86, 8'h35, 8'h77, 8'hba, 8'h0a, 8'h41};
            wr_q[0] = wr_q[0] ^ 8'(b);
            send_cmd(1'b0, addrs[b], 2'd1, 1'b0);
            fill(1'b0);
            capture_wr(addrs[b]);
            tests++; if (cap_n != 8 || cap_split) begin fails++; $display("FAIL b2b_len%0d: got %0d split=%0b want 8 contiguous", b, cap_n, cap_split); end
            tests++; if (!cap_addr_ok) begin fails++; $display("FAIL b2b_addr%0d: got unstable addr want %h", b, addrs[b]); end
            tests++; if (cap[0] !== wr_q[0] || cap[7] !== wr_q[7]) begin fails++; $display("FAIL b2b_data%0d: got %h..%h want %h..%h", b, cap[0], cap[7], wr_q[0], wr_q[7]); end
            tests++; if (cap_gap < 2) begin fails++; $display("FAIL b2b_gap%0d: got %0d want >=2", b, cap_gap); end
        end
    endtask

    task automatic test_read();
        logic [7:0] rd_exp [0:7];
        logic [7:0] got [0:7];
        int ns = 0, nr = 0, no = 0, nb = 0, k = 0, cyc = 0;
        bit seen = 0;
        rd_exp = '{8'h87, 8'h08, 8'h9b, 8'h75, 8'h56, 8'h2a, 8'h28, 8'ha9};
        mmu_ready = 1'b1;
        send_cmd(1'b1, 4'h3, 2'd1, 1'b0);
        while (!(seen && cmd_ready) && cyc < 100) begin
            if (busy) nb++;
            if (out_valid) begin
                if (no < 8) got[no] = out_data;
                no++;
            end
            mmu_rd_data = 8'h5a;
            if (mmu_start) begin
                seen = 1;
                ns++;
                if (mmu_rw_ena) nr++;
                if (k >= 2 && k < 10) mmu_rd_data = rd_exp[k-2];
                k++;
            end
            tick();
            cyc++;
        end
        tests++; if (cyc >= 100) begin fails++; $display("FAIL rd_timeout: read not finished in 100 cycles"); end
        tests++; if (ns != 10) begin fails++; $display("FAIL rd_start_len: got %0d want 10", ns); end
        tests++; if (nr != 10) begin fails++; $display("FAIL rd_rw_ena_len: got %0d want 10", nr); end
        tests++; if (no != 8) begin fails++; $display("FAIL rd_out_count: got %0d want 8", no); end
        tests++; if (nb != 13) begin fails++; $display("FAIL rd_busy: got %0d want 13", nb); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got[i] !== rd_exp[i]) begin fails++; $display("FAIL rd_byte%0d: got %h want %h", i, got[i], rd_exp[i]); end
        end
    endtask

    task automatic test_stalls();
        wr_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        mmu_ready = 1'b0;
        send_cmd(1'b0, 4'h9, 2'd1, 1'b0);
        fill(1'b1);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mmu_start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: got start=%0b busy=%0b in_ready=%0b want 0 1 0", i, mmu_start, busy, in_ready);
            end
            // junk offered while waiting must be refused
            in_valid = 1'b1;
            in_data  = 8'hff;
            tick();
        end
        in_valid  = 1'b0;
        mmu_ready = 1'b1;
        capture_wr(4'h9);
        tests++; if (cap_n != 8 || cap_split) begin fails++; $display("FAIL stall_len: got %0d split=%0b want 8 contiguous", cap_n, cap_split); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (cap[i] !== wr_q[i]) begin fails++; $display("FAIL stall_byte%0d: got %h want %h", i, cap[i], wr_q[i]); end
        end
        tests++; if (cap_busy != 11) begin fails++; $display("FAIL stall_busy: got %0d want 11", cap_busy); end
    endtask

    task automatic test_frame_len();
        mmu_ready = 1'b1;
        wr_q = '{8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7};
        send_cmd(1'b0, 4'h4, 2'd0, 1'b0);
        fill(1'b0);
        capture_wr(4'h4);
        tests++; if (cap_n != 8) begin fails++; $display("FAIL frame0_len: got %0d want 8", cap_n); end
        tests++; if (cap[7] !== 8'hc7) begin fails++; $display("FAIL frame0_last: got %h want c7", cap[7]); end
        wr_q.delete();
        for (int i = 0; i < 24; i++) wr_q.push_back(8'(8'h40 + i * 3));
        send_cmd(1'b0, 4'hb, 2'd3, 1'b0);
        fill(1'b0);
        capture_wr(4'hb);
        tests++; if (cap_n != 24 || cap_split) begin fails++; $display("FAIL frame3_len: got %0d split=%0b want 24 contiguous", cap_n, cap_split); end
        tests++; if (cap_frame !== 2'd3) begin fails++; $display("FAIL frame3_frame: got %0d want 3", cap_frame); end
        for (int i = 0; i < 24; i++) begin
            tests++;
            if (cap[i] !== wr_q[i]) begin fails++; $display("FAIL frame3_byte%0d: got %h want %h", i, cap[i], wr_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        mmu_ready = 1'b1;
        wr_q = '{8'hd0, 8'hd1, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7};
        send_cmd(1'b0, 4'h6, 2'd1, 1'b0);
        fill(1'b0);
        for (int c = 0; c < 20; c++) begin
            if (mmu_start) k++;
            if (k == 5) break;
            tick();
        end
        tests++; if (k != 5) begin fails++; $display("FAIL rstmid_reach: got %0d burst cycles want 5", k); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (mmu_start !== 1'b0) begin fails++; $display("FAIL rstmid_start: got %0b want 0", mmu_start); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_cmd_ready: got %0b want 1", cmd_ready); end
        wr_q = '{8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'he6, 8'he7};
        send_cmd(1'b0, 4'h7, 2'd1, 1'b0);
        fill(1'b0);
        capture_wr(4'h7);
        tests++; if (cap_n != 8) begin fails++; $display("FAIL rstmid_len: got %0d want 8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (cap[i] !== wr_q[i]) begin fails++; $display("FAIL rstmid_byte%0d: got %h want %h", i, cap[i], wr_q[i]); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b0;
        cmd_addr    = '0;
        cmd_frame   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        mmu_ready   = 1'b0;
        mmu_rd_data = '0;
        repeat (3) tick();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_stalls();
        test_frame_len();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
